mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised memory-access sequencer between the multi-cycle core and a shared instruction/data memory bus. Replaces the single-cycle combinational read/write path with a registered request/acknowledge bus that tolerates variable wait states. Arbitrates fetch and load/store requests, generates byte enables, and sign/zero-extends loads. Flags misaligned accesses, illegal sizes and bus timeouts.

Parameters:
DATA_W, 32, bus/data width; legal values 32 or 64
ADDR_W, 32, byte address width
TIMEOUT_CYCLES, 255, max bus_req cycles without bus_ack before error; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
if_req  in  1  fetch request; held until if_valid
if_addr  in  ADDR_W  fetch byte address
if_valid  out  1  one-cycle pulse: fetch done
if_rdata  out  32  fetched instruction
d_req  in  1  load/store request; held until d_valid
d_we  in  1  1 = store
d_funct3  in  3  RISC-V size/sign code
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data, right-aligned
d_valid  out  1  one-cycle pulse: data access done
d_rdata  out  DATA_W  extended load data
err  out  1  valid with if_valid/d_valid: misaligned, illegal size or timeout
busy  out  1  state != IDLE
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  bus write
bus_addr  out  ADDR_W  word-aligned address (low log2(DATA_W/8) bits zero)
bus_be  out  DATA_W/8  byte enables
bus_wdata  out  DATA_W  lane-shifted store data
bus_ack  in  1  bus completes in the cycle it is high with bus_req
bus_rdata  in  DATA_W  read data, valid with bus_ack

Behaviour:
- Reset (async, immediate): state IDLE. All outputs are 0, and the timeout counter is 0. A bus transaction in flight is abandoned with no valid pulse.
- FSM: IDLE -> BUS -> RESP -> IDLE. Faults use the path IDLE -> RESP.
- IDLE: samples requests at the clock edge. If d_req and if_req are both high, data wins and the fetch stays pending; it is serviced after RESP. Requests are ignored outside IDLE.
- Accept: address, lane, funct3 and we are latched. bus_* outputs are registered and asserted the next cycle.
- BUS: bus_req holds until bus_ack. On the ack edge, rdata is captured and the state goes to RESP.
- RESP: exactly one cycle. The matching valid is high, and rdata/err are stable in that cycle. The state then returns to IDLE.
- Minimum latency: request in cycle N, bus_req in N+1, ack in N+1, valid in N+2. Each wait state adds 1 cycle.
- Fetch: always a 32-bit access; bus_be covers that word. When DATA_W=64, addr[2] selects the half. If addr[1:0] != 0: err, no bus cycle, if_rdata = 0.
- Sizes: funct3 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - With DATA_W=64, 011 LD/SD and 110 LWU are also legal.
  - Any other code, or a store with funct3[2]=1, raises err with no bus cycle.
- Alignment: the address must be a multiple of the access size, otherwise err with no bus cycle. d_rdata = 0 on any err.
- Store lanes: wdata is shifted to the byte offset, and bus_be has only the addressed bytes set.
- Load extension: signed codes sign-extend from the top bit of the selected bytes to DATA_W; unsigned codes zero-extend.
- Timeout: the counter increments each BUS cycle. When it reaches TIMEOUT_CYCLES without ack, bus_req drops, the state goes to RESP with err=1, and rdata = 0. The counter clears on leaving BUS.
- An ack in the same cycle as the timeout is treated as success.
- bus_ack outside BUS is ignored.

Optional Feature:
MAU_PERF_CNT_EN defined adds three outputs, each a 32-bit wrapping counter cleared by reset:
- perf_fetches: completed fetches
- perf_data: completed loads/stores
- perf_wait: BUS cycles with bus_ack low

When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
1. DATA_W=32, if_req addr 0x10, ack immediate, bus_rdata 0x00A00093 -> bus_req in cycle N+1, if_valid in N+2, if_rdata 0x00A00093, err 0.
2. SB addr 0x103, wdata 0x000000AB, 2 wait states -> bus_addr 0x100, be 4'b1000, bus_wdata 0xAB000000, d_valid 4 cycles after request.
3. LH addr 0x22, bus_rdata 0x8001xxxx -> d_rdata 0xFFFF8001. LHU from the same address -> d_rdata 0x00008001.
4. LW addr 0x06 -> no bus_req, d_valid next cycle with err 1 and d_rdata 0. funct3 011 at DATA_W=32 -> err 1.
5. if_req and d_req high together -> data serviced first, then fetch. Exactly one valid per transaction.
6. TIMEOUT_CYCLES=4 with no ack -> bus_req high 4 cycles then low, then d_valid with err 1. rst_n low mid-BUS -> bus_req 0 immediately, no valid pulse.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/acknowledge memory bus between the access unit (master) and memory (slave)
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  we;
    logic                  ack;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;

    modport master(output req, we, addr, be, wdata, input ack, rdata);
    modport slave(input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: fetch/load-store sequencer onto a wait-state bus; MAU_PERF_CNT_EN adds perf counters
module mem_access_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_valid,
    output logic [31:0]         if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [2:0]          d_funct3,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                err,
    output logic                busy,
`ifdef MAU_PERF_CNT_EN
    output logic [31:0]         perf_fetches,
    output logic [31:0]         perf_data,
    output logic [31:0]         perf_wait,
`endif
    mem_access_unit_if.master   bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CW    = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_nx;

    logic              is_d_r, we_r, err_r;
    logic [2:0]        f3_r;
    logic [OFF_W-1:0]  off_r;
    logic [ADDR_W-1:0] addr_r;
    logic [BE_W-1:0]   be_r;
    logic [DATA_W-1:0] wdata_r, rdata_r;
    logic [CW-1:0]     cnt;

    logic              accept, legal, misal, fault, tmo, sgn;
    logic [ADDR_W-1:0] a_addr;
    logic [2:0]        a_f3;
    logic [1:0]        sz;
    logic [OFF_W-1:0]  a_off;
    logic [BE_W-1:0]   a_be;
    logic [DATA_W-1:0] sh, mask, ext;

    // request decode (data wins over fetch), bus timeout and load lane/extension
    always_comb begin
        accept = d_req | if_req;
        a_addr = d_req ? d_addr : if_addr;
        a_f3   = d_req ? d_funct3 : 3'b010;
        sz     = a_f3[1:0];
        a_off  = a_addr[OFF_W-1:0];
        legal  = !d_req || ((a_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101} ||
                 (DATA_W == 64 && a_f3 inside {3'b011, 3'b110})) && !(d_we && a_f3[2]));
        misal  = sz == 2'd1 ? a_addr[0] : sz == 2'd2 ? |a_addr[1:0] : sz == 2'd3 ? |a_addr[2:0] : 1'b0;
        fault  = !legal || misal;
        a_be   = BE_W'(sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF) << a_off;
        tmo    = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1) && !bus.ack;
        sh     = bus.rdata >> {off_r, 3'b000};
        mask   = f3_r[1:0] == 2'd0 ? DATA_W'(8'hFF) : f3_r[1:0] == 2'd1 ? DATA_W'(16'hFFFF) :
                 f3_r[1:0] == 2'd2 ? DATA_W'(32'hFFFF_FFFF) : '1;
        sgn    = !f3_r[2] && (f3_r[1:0] == 2'd0 ? sh[7] : f3_r[1:0] == 2'd1 ? sh[15] :
                 f3_r[1:0] == 2'd2 ? sh[31] : sh[DATA_W-1]);
        ext    = sgn ? sh | ~mask : sh & mask;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: faults skip the bus; ack beats a simultaneous timeout
    always_comb begin
        state_nx = state == IDLE ? (accept ? (fault ? RESP : BUS) : IDLE) :
                   state == BUS  ? ((bus.ack || tmo) ? RESP : BUS) : IDLE;
    end

    // outputs decoded from state and latched transaction fields
    always_comb begin
        busy      = state != IDLE;
        bus.req   = state == BUS;
        bus.we    = bus.req && we_r;
        bus.addr  = addr_r;
        bus.be    = be_r;
        bus.wdata = wdata_r;
        if_valid  = state == RESP && !is_d_r;
        d_valid   = state == RESP && is_d_r;
        err       = state == RESP && err_r;
        if_rdata  = rdata_r[31:0];
        d_rdata   = rdata_r;
    end

    // latch the accepted request, then count wait cycles and capture read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_d_r  <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            f3_r    <= '0;
            off_r   <= '0;
            addr_r  <= '0;
            be_r    <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            cnt     <= '0;
        end else if (state == IDLE && accept) begin
            is_d_r  <= d_req;
            we_r    <= d_req && d_we;
            err_r   <= fault;
            f3_r    <= a_f3;
            off_r   <= a_off;
            addr_r  <= {a_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            be_r    <= a_be;
            wdata_r <= (d_req && d_we) ? d_wdata << {a_off, 3'b000} : '0;
            rdata_r <= '0;
        end else if (state == BUS) begin
            cnt   <= (bus.ack || tmo) ? '0 : cnt + CW'(1);
            err_r <= tmo;
            if (bus.ack && !we_r) rdata_r <= ext;
        end
    end

`ifdef MAU_PERF_CNT_EN
    // wrapping event counters for completed fetches, data accesses and wait cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetches <= '0;
            perf_data    <= '0;
            perf_wait    <= '0;
        end else begin
            perf_fetches <= perf_fetches + 32'(if_valid);
            perf_data    <= perf_data + 32'(d_valid);
            perf_wait    <= perf_wait + 32'(state == BUS && !bus.ack);
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit (DATA_W=32, TIMEOUT_CYCLES=4)
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [2:0]  d_funct3 = '0;
    logic        if_valid, d_valid, err, busy;
    logic [31:0] if_rdata, d_rdata;
`ifdef MAU_PERF_CNT_EN
    logic [31:0] perf_fetches, perf_data, perf_wait;
`endif
    int cyc = 0;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata), .err(err), .busy(busy),
`ifdef MAU_PERF_CNT_EN
        .perf_fetches(perf_fetches), .perf_data(perf_data), .perf_wait(perf_wait),
`endif
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          waits;
        logic [31:0] rdata;
        int          len;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          lat;
        int          issue;
    } resp_t;

    bus_t  bq[$];
    resp_t dq[$], fq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // bus slave: checks each new request against the expected queue and acks after its wait states
    initial begin
        logic active = 1'b0;
        int   wc = 0, blen = 0;
        bus_t cur;
        bus.ack = 1'b0;
        bus.rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.req) begin
                if (!active) begin
                    active = 1'b1;
                    blen = 0;
                    if (bq.size() == 0) begin
                        flag("unexpected bus_req");
                        cur.waits = 1000;
                        cur.len = 0;
                        cur.rdata = '0;
                    end else begin
                        cur = bq.pop_front();
                        chk("bus_addr", bus.addr, cur.addr);
                        chk("bus_be", bus.be, cur.be);
                        chk("bus_wdata", bus.wdata, cur.wdata);
                        chk("bus_we", bus.we, cur.we);
                    end
                    wc = cur.waits;
                end
                blen++;
                if (wc == 0) begin
                    bus.ack = 1'b1;
                    bus.rdata = cur.rdata;
                end else begin
                    bus.ack = 1'b0;
                    wc--;
                end
            end else begin
                if (active && cur.len > 0) chk("bus_req cycles", 64'(blen), 64'(cur.len));
                active = 1'b0;
                bus.ack = 1'b0;
            end
        end
    end

    // response monitor: pops the expected response for whichever valid pulses
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (if_valid && d_valid) flag("if_valid and d_valid together");
            if (d_valid) begin
                if (dq.size() == 0) flag("unexpected d_valid");
                else begin
                    r = dq.pop_front();
                    chk("d_err", err, r.err);
                    if (r.chk_rd) chk("d_rdata", d_rdata, r.rdata);
                    if (r.lat > 0) chk("d_latency", 64'(cyc - r.issue), 64'(r.lat));
                end
            end
            if (if_valid) begin
                if (fq.size() == 0) flag("unexpected if_valid");
                else begin
                    r = fq.pop_front();
                    chk("if_err", err, r.err);
                    chk("if_rdata", if_rdata, r.rdata);
                    if (r.lat > 0) chk("if_latency", 64'(cyc - r.issue), 64'(r.lat));
                end
            end
        end
    end

    task automatic wait_valid(input logic is_d);
        logic got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = is_d ? d_valid : if_valid;
        end
        if (!got) flag(is_d ? "d_valid wait expired" : "if_valid wait expired");
        @(posedge clk);
        #1;
        if (is_d) d_req = 1'b0;
        else if_req = 1'b0;
    endtask

    task automatic d_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic bus_on, input logic [31:0] baddr, input logic [3:0] be, input logic [31:0] bwd,
                         input int waits, input logic [31:0] brd, input int len,
                         input logic [31:0] erd, input logic eerr, input int lat);
        if (bus_on) bq.push_back('{baddr, be, bwd, we, waits, brd, len});
        dq.push_back('{erd, eerr, !we || eerr, lat, cyc});
        d_we = we;
        d_funct3 = f3;
        d_addr = addr;
        d_wdata = wd;
        d_req = 1'b1;
        wait_valid(1'b1);
    endtask

    task automatic f_txn(input logic [31:0] addr, input logic bus_on, input int waits, input logic [31:0] brd,
                         input logic [31:0] erd, input logic eerr, input int lat);
        if (bus_on) bq.push_back('{addr, 4'hF, 32'h0, 1'b0, waits, brd, waits + 1});
        fq.push_back('{erd, eerr, 1'b1, lat, cyc});
        if_addr = addr;
        if_req = 1'b1;
        wait_valid(1'b0);
    endtask

    initial begin
        #2;
        chk("reset bus_req", bus.req, 0);
        chk("reset busy", busy, 0);
        chk("reset valids", {if_valid, d_valid, err}, 0);
        chk("reset bus_addr", bus.addr, 0);
        chk("reset bus_be", bus.be, 0);
        chk("reset bus_wdata", bus.wdata, 0);
        chk("reset rdata", {if_rdata, d_rdata}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // fetch, zero wait states
        f_txn(32'h10, 1, 0, 32'h00A00093, 32'h00A00093, 0, 2);
        // stores: lane shift and byte enables, with wait states
        d_txn(1, 3'b000, 32'h103, 32'hAB, 1, 32'h100, 4'b1000, 32'hAB000000, 2, 0, 3, 0, 0, 4);
        d_txn(1, 3'b010, 32'h200, 32'hDEADBEEF, 1, 32'h200, 4'b1111, 32'hDEADBEEF, 1, 0, 2, 0, 0, 3);
        d_txn(1, 3'b001, 32'h202, 32'h1234, 1, 32'h200, 4'b1100, 32'h12340000, 0, 0, 1, 0, 0, 2);
        // loads: lane select with sign/zero extension
        d_txn(0, 3'b001, 32'h22, 0, 1, 32'h20, 4'b1100, 0, 0, 32'h80011234, 1, 32'hFFFF8001, 0, 2);
        d_txn(0, 3'b101, 32'h22, 0, 1, 32'h20, 4'b1100, 0, 0, 32'h80011234, 1, 32'h00008001, 0, 2);
        d_txn(0, 3'b000, 32'h41, 0, 1, 32'h40, 4'b0010, 0, 0, 32'h00008000, 1, 32'hFFFFFF80, 0, 2);
        d_txn(0, 3'b100, 32'h43, 0, 1, 32'h40, 4'b1000, 0, 0, 32'h7F000000, 1, 32'h0000007F, 0, 2);
        d_txn(0, 3'b000, 32'h40, 0, 1, 32'h40, 4'b0001, 0, 1, 32'h1234567F, 2, 32'h0000007F, 0, 3);
        d_txn(0, 3'b010, 32'h44, 0, 1, 32'h44, 4'b1111, 0, 0, 32'h87654321, 1, 32'h87654321, 0, 2);
        // faults: no bus cycle, error response the next cycle
        d_txn(0, 3'b010, 32'h06, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        d_txn(0, 3'b011, 32'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        d_txn(1, 3'b100, 32'h00, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        d_txn(0, 3'b111, 32'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        d_txn(0, 3'b001, 32'h21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        f_txn(32'h12, 0, 0, 0, 0, 1, 1);
        // simultaneous requests: data first, fetch afterwards
        fork
            d_txn(0, 3'b010, 32'h30, 0, 1, 32'h30, 4'hF, 0, 0, 32'h11111111, 1, 32'h11111111, 0, 2);
            begin
                #1;
                f_txn(32'h34, 1, 0, 32'h22222222, 32'h22222222, 0, 5);
            end
        join
        // timeout with no ack, and ack on the last allowed cycle
        d_txn(0, 3'b010, 32'h40, 0, 1, 32'h40, 4'hF, 0, 100, 0, 4, 0, 1, 5);
        d_txn(0, 3'b010, 32'h48, 0, 1, 32'h48, 4'hF, 0, 3, 32'hCAFEF00D, 4, 32'hCAFEF00D, 0, 5);
        // asynchronous reset in the middle of a bus wait: no response
        bq.push_back('{32'h50, 4'hF, 32'h0, 1'b0, 100, 32'h0, 0});
        d_we = 1'b0;
        d_funct3 = 3'b010;
        d_addr = 32'h50;
        d_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("bus_req before reset", bus.req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("bus_req after async reset", bus.req, 0);
        chk("busy after async reset", busy, 0);
        d_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        f_txn(32'h60, 1, 1, 32'h00000013, 32'h00000013, 0, 3);
        repeat (3) @(posedge clk);
        chk("scoreboard drained", 64'(bq.size() + dq.size() + fq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
